// File: rtl/cpu_trace_pkg.sv
// Shared types for the performance trace transmitter: the snapshot record,
// the record framing constants and the transmitter state encoding.
package cpu_trace_pkg;

  localparam logic [7:0]  TRACE_HDR     = 8'hA5;
  localparam int unsigned WORDS_PER_REC = 4;
  localparam logic [1:0]  LAST_IDX      = 2'(WORDS_PER_REC - 1);

  typedef struct packed {
    logic [31:0] cycle;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [31:0] pc;
  } trace_rec_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  // Word idx of a record as it appears on the trace bus.
  function automatic logic [31:0] rec_word(input trace_rec_t rec, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = {TRACE_HDR, rec.cycle[23:0]};
      2'd1:    w = rec.stall;
      2'd2:    w = rec.flush;
      2'd3:    w = rec.pc;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the trace transmitter. Exposes the head record and the one
// behind it so the sender can start the next record without a bubble.
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  trace_rec_t push_data,
  input  logic       pop,
  output trace_rec_t head,
  output trace_rec_t head_next,
  output logic       full,
  output logic       empty,
  output logic       multi
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t      mem_r [DEPTH];
  logic [AW:0]     wr_ptr_r;
  logic [AW:0]     rd_ptr_r;
  logic [AW:0]     count_s;
  logic [AW-1:0]   rd_next_s;

  assign count_s   = wr_ptr_r - rd_ptr_r;
  assign full      = (count_s == (AW+1)'(DEPTH));
  assign empty     = (count_s == {(AW+1){1'b0}});
  assign multi     = (count_s > (AW+1)'(1));
  assign rd_next_s = rd_ptr_r[AW-1:0] + AW'(1);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];
  assign head_next = mem_r[rd_next_s];

  // Read/write pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push && !full) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop && !empty) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Record storage.
  always_ff @(posedge clk_i) begin
    if (push && !full) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/perf_trace_tx.sv
// Cycle/stall/flush performance counters with periodic PC snapshots, streamed
// as 4-word records over a valid/ready trace port.
module perf_trace_tx
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int INTERVAL = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        bubble_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        flush1_i,
  input  logic        flush2_i,
  input  logic [31:0] pc_i,
  output logic        tr_valid_o,
  output logic [31:0] tr_data_o,
  output logic        tr_last_o,
  input  logic        tr_ready_i,
  output logic [15:0] drop_cnt_o
);

  localparam int IW = $clog2(INTERVAL);

  logic [31:0]   cyc_r, stall_r, flush_r;
  logic [IW-1:0] intv_r;
  logic [15:0]   drop_r;
  logic          stall_ev_s, flush_ev_s, snap_s, push_s, pop_s, hs_s;
  logic          full_s, empty_s, multi_s;
  trace_rec_t    snap_rec_s, head_s, head_next_s;
  tx_state_t     state_r, state_s;
  logic [1:0]    idx_r, idx_s;
  logic          valid_s, last_s;
  logic [31:0]   data_s;

  assign stall_ev_s = bubble_i & ~jump_i & ~branch_i;
  assign flush_ev_s = flush1_i | flush2_i;
  assign snap_s     = start_i & (intv_r == {IW{1'b0}});
  assign push_s     = snap_s & ~full_s;
  assign hs_s       = tr_valid_o & tr_ready_i;
  assign drop_cnt_o = drop_r;

  // Snapshot carries the pre-increment cycle count but this edge's events.
  assign snap_rec_s.cycle = cyc_r;
  assign snap_rec_s.stall = stall_r + {31'd0, stall_ev_s};
  assign snap_rec_s.flush = flush_r + {31'd0, flush_ev_s};
  assign snap_rec_s.pc    = pc_i;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push_s),
    .push_data (snap_rec_s),
    .pop       (pop_s),
    .head      (head_s),
    .head_next (head_next_s),
    .full      (full_s),
    .empty     (empty_s),
    .multi     (multi_s)
  );

  // Performance counters and snapshot interval, frozen while the CPU is stopped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_r   <= 32'd0;
      stall_r <= 32'd0;
      flush_r <= 32'd0;
      intv_r  <= {IW{1'b0}};
    end else if (start_i) begin
      cyc_r   <= cyc_r + 32'd1;
      stall_r <= snap_rec_s.stall;
      flush_r <= snap_rec_s.flush;
      intv_r  <= (intv_r == IW'(INTERVAL - 1)) ? {IW{1'b0}} : intv_r + IW'(1);
    end
  end

  // Saturating count of snapshots lost to a full FIFO.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      drop_r <= 16'd0;
    end else if (snap_s && full_s && (drop_r != 16'hFFFF)) begin
      drop_r <= drop_r + 16'd1;
    end
  end

  // Transmitter next state and next registered bus values.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    valid_s = tr_valid_o;
    data_s  = tr_data_o;
    last_s  = tr_last_o;
    pop_s   = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (!empty_s) begin
          state_s = TX_SEND;
          idx_s   = 2'd0;
          valid_s = 1'b1;
          data_s  = rec_word(head_s, 2'd0);
          last_s  = 1'b0;
        end else begin
          valid_s = 1'b0;
          data_s  = 32'd0;
          last_s  = 1'b0;
        end
      end
      TX_SEND: begin
        if (hs_s && (idx_r == LAST_IDX)) begin
          pop_s  = 1'b1;
          idx_s  = 2'd0;
          last_s = 1'b0;
          // Next record is either already queued or being pushed this edge.
          if (multi_s) begin
            data_s = rec_word(head_next_s, 2'd0);
          end else if (push_s) begin
            data_s = rec_word(snap_rec_s, 2'd0);
          end else begin
            state_s = TX_IDLE;
            valid_s = 1'b0;
            data_s  = 32'd0;
          end
        end else if (hs_s) begin
          idx_s  = idx_r + 2'd1;
          data_s = rec_word(head_s, idx_r + 2'd1);
          last_s = ((idx_r + 2'd1) == LAST_IDX);
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = TX_IDLE;
        idx_s   = 2'd0;
        valid_s = 1'b0;
        data_s  = 32'd0;
        last_s  = 1'b0;
      end
    endcase
  end

  // Transmitter state and registered trace outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= TX_IDLE;
      idx_r      <= 2'd0;
      tr_valid_o <= 1'b0;
      tr_data_o  <= 32'd0;
      tr_last_o  <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      tr_valid_o <= valid_s;
      tr_data_o  <= data_s;
      tr_last_o  <= last_s;
    end
  end

endmodule

// File: doc/perf_trace_tx.md
# perf_trace_tx

Per-cycle performance counter and trace transmitter inside the pipelined CPU, alongside the hazard-detection and IF/ID flush logic. It counts cycles, load-use stalls and control flushes, snapshots them with the current PC at a programmable interval, and streams each snapshot as a 4-word record over a valid/ready interface to an off-chip logger. The testbench's per-cycle status dump reads the CPU from outside; this block is the in-design sender of that same status.

## Interface
Parameters:
- `DEPTH`, 4, record FIFO depth in records (power of two, ≥2)
- `INTERVAL`, 4, cycles between snapshots (≥4, so one record per interval drains at full rate)

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; one clock, reset is asynchronous and active-low
- `start_i`  in  1  CPU running; gates counting and sampling
- `bubble_i`  in  1  hazard-detection bubble
- `jump_i`  in  1  control: jump decoded
- `branch_i`  in  1  control: branch decoded
- `flush1_i`, `flush2_i`  in  1 each  IF/ID flush requests
- `pc_i`  in  32  current PC
- `tr_valid_o`  out  1  trace word valid
- `tr_data_o`  out  32  trace word
- `tr_last_o`  out  1  final word of record
- `tr_ready_i`  in  1  sink accepts word
- `drop_cnt_o`  out  16  records dropped on full FIFO, saturating

## Operation
- Stall event: `bubble_i & ~jump_i & ~branch_i`. Flush event: `flush1_i | flush2_i`.
- While `start_i`=1, each posedge: cycle counter +1; stall/flush counters +1 on their event. All 32-bit, wrap modulo 2^32. While `start_i`=0 all counters hold and no snapshots are taken; draining continues.
- Interval counter counts 0..INTERVAL-1 while `start_i`=1; snapshot when it is 0 (first running cycle is a snapshot).
- Snapshot contents: cycle = counter value before this edge's increment (first record cycle=0); stall/flush = counts including this cycle's events; PC = `pc_i` at this edge.
- Record words, in order: W0 = `{8'hA5, cycle[23:0]}`, W1 = stall, W2 = flush, W3 = PC; `tr_last_o`=1 on W3 only.
- FIFO full at a snapshot edge (full evaluated before any same-edge pop): record discarded, `drop_cnt_o` +1, saturating at 16'hFFFF. Counters unaffected.
- Transmitter FSM: IDLE → SEND(word index 0..3). IDLE with FIFO non-empty → SEND idx 0. In SEND, handshake (`tr_valid_o & tr_ready_i`) advances idx; handshake at idx 3 pops record, then SEND idx 0 if FIFO still non-empty, else IDLE.
- `tr_data_o`/`tr_last_o` stable while `tr_valid_o & ~tr_ready_i`; valid never drops without a handshake.

## Timing
- Reset (async, `rst_i`=0): all counters, interval counter, drop count, FIFO pointers 0; FSM IDLE; `tr_valid_o`=0, `tr_data_o`=0, `tr_last_o`=0, `drop_cnt_o`=0. Reset mid-record abandons it; no partial word after release.
- Latency: snapshot at edge N into empty FIFO → W0 valid after edge N+1. With `tr_ready_i`=1 a record takes exactly 4 cycles; back-to-back records with no idle cycle.
- Simultaneous push and pop on non-full FIFO: both occur, count unchanged.
- `tr_ready_i` may be asserted without valid; ignored.

## Structure
- Package `cpu_trace_pkg`: record struct (cycle, stall, flush, pc), header constant 8'hA5, words-per-record constant 4, FSM state enum.
- Sub-module `trace_fifo`: synchronous FIFO of records, DEPTH entries, full/empty flags, async active-low reset.

## Test plan
- Reset held, then release with `start_i`=1, `pc_i`=0, ready=1 → first record W0=32'hA5000000, W1=0, W2=0, W3=0, `tr_last_o` on W3 only.
- Bubble pulse with jump=branch=0 in cycle 2, bubble with branch=1 in cycle 3, flush1 in cycle 6 → record at cycle 4: stall=1, flush=0; record at cycle 8: stall=1, flush=1.
- `tr_ready_i`=0 for 40 cycles with DEPTH=4 → exactly 4 records retained, `drop_cnt_o`=6; ready=1 → 4 records cycle 0,4,8,12 emitted in order, data stable during backpressure.
- `start_i` low for 10 cycles mid-run → no records, cycle count resumes from held value, W0 gap equals 0 extra.
- Assert `rst_i`=0 during W2 of a record → outputs 0 immediately; after release next record W0 cycle=0.
